// File: rtl/scsi_pkg.sv
// Shared types and widths for the SCSI-target / host block-device channel arbiter.
package scsi_pkg;

    localparam int LBA_W = 32;
    localparam int BUF_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        XFER,
        RELEASE
    } state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } op_t;

endpackage

// File: rtl/scsi_sd_arbiter_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // ptr is assumed to be < N, so a single subtraction is enough to wrap.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    always_comb begin
        onehot = '0;
        idx    = '0;
        valid  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!valid && req[wrap_add(ptr, k)]) begin
                valid = 1'b1;
                idx   = wrap_add(ptr, k);
            end
        end
        if (valid) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/scsi_sd_arbiter.sv
// Shares the single host sector channel between NUM_TGT SCSI targets, one sector transfer per
// round-robin grant, with LBA/direction frozen for the transfer and ack/buffer strobes steered.
module scsi_sd_arbiter
    import scsi_pkg::*;
#(
    parameter int NUM_TGT     = 2,
    parameter int TIMEOUT_CYC = 2**20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [32*NUM_TGT-1:0]    tgt_lba,
    input  logic [NUM_TGT-1:0]       tgt_rd,
    input  logic [NUM_TGT-1:0]       tgt_wr,
    output logic [NUM_TGT-1:0]       tgt_ack,
    input  logic [16*NUM_TGT-1:0]    tgt_buff_din,
    output logic [NUM_TGT-1:0]       tgt_buff_wr,
    output logic [31:0]              sd_lba,
    output logic                     sd_rd,
    output logic                     sd_wr,
    input  logic                     sd_ack,
    output logic [15:0]              sd_buff_din,
    input  logic                     sd_buff_wr,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int IW = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t             state_q, state_d;
    logic [IW-1:0]      grant_q, grant_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    op_t                op_q, op_d;
    logic [LBA_W-1:0]   lba_q, lba_d;
    logic               issuing_q, issuing_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               tmo_q, tmo_d;

    logic [NUM_TGT-1:0] req;
    logic [NUM_TGT-1:0] pick_onehot;
    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               pick_is_rd;
    logic [LBA_W-1:0]   lba_arr [NUM_TGT];
    logic [BUF_W-1:0]   din_arr [NUM_TGT];

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        if (int'(g) == NUM_TGT - 1) begin
            return '0;
        end
        return g + 1'b1;
    endfunction

    assign req = tgt_rd | tgt_wr;

    always_comb begin
        for (int i = 0; i < NUM_TGT; i++) begin
            lba_arr[i] = tgt_lba[LBA_W*i +: LBA_W];
            din_arr[i] = tgt_buff_din[BUF_W*i +: BUF_W];
        end
    end

    rr_pick #(
        .N  (NUM_TGT),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .ptr    (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    // A target asserting both rd and wr is served as a read.
    assign pick_is_rd = |(pick_onehot & tgt_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            op_q      <= OP_RD;
            lba_q     <= '0;
            issuing_q <= 1'b0;
            timer_q   <= '0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            op_q      <= op_d;
            lba_q     <= lba_d;
            issuing_q <= issuing_d;
            timer_q   <= timer_d;
            tmo_q     <= tmo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        op_d      = op_q;
        lba_d     = lba_q;
        issuing_d = issuing_q;
        timer_d   = timer_q;
        tmo_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // A stale host ack must drain before anyone is granted.
                if (pick_valid && !sd_ack) begin
                    grant_d   = pick_idx;
                    lba_d     = lba_arr[pick_idx];
                    op_d      = pick_is_rd ? OP_RD : OP_WR;
                    issuing_d = 1'b1;
                    timer_d   = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (sd_ack) begin
                    issuing_d = 1'b0;
                    state_d   = XFER;
                end else if (!req[grant_q]) begin
                    issuing_d = 1'b0;
                    rr_ptr_d  = next_ptr(grant_q);
                    state_d   = IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    issuing_d = 1'b0;
                    tmo_d     = 1'b1;
                    rr_ptr_d  = next_ptr(grant_q);
                    state_d   = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                rr_ptr_d = next_ptr(grant_q);
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only the owner sees host ack/strobes, and only while it actually owns the channel.
    always_comb begin
        tgt_ack     = '0;
        tgt_buff_wr = '0;
        if (state_q == ISSUE || state_q == XFER) begin
            tgt_ack[grant_q]     = sd_ack;
            tgt_buff_wr[grant_q] = sd_buff_wr;
        end
    end

    assign sd_buff_din = din_arr[grant_q];
    assign sd_lba      = lba_q;
    assign sd_rd       = issuing_q && (op_q == OP_RD);
    assign sd_wr       = issuing_q && (op_q == OP_WR);
    assign busy        = (state_q != IDLE);
    assign timeout_err = tmo_q;

endmodule
